// File: rtl/common_pkg.sv
// Shared elaboration helpers: width arithmetic used to size CXU-LI fields.
package common_pkg;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Zero-width fields still get one bit on the wire.
  function automatic int msb(input int w);
    return max(w - 1, 0);
  endfunction

endpackage

// File: rtl/cxu_pkg.sv
// CXU-LI response status width and encodings.
package cxu_pkg;

  localparam int CXU_STATUS_W = 3;

  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_ERROR = 3'd0;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_OFF   = 3'd1;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_DIRTY = 3'd2;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_CLEAN = 3'd3;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_OK    = 3'd4;

endpackage

// File: rtl/cxu_tag_fifo.sv
// In-order tag FIFO: records the owning initiator of each outstanding request.
// Pushes are dropped when full, pops when empty; both are held off by clk_en.
module cxu_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = clk_en & i_push & ~o_full;
  assign w_do_pop  = clk_en & i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cxu_arbiter_n1.sv
// N-to-1 CXU-LI arbiter: round-robin request grant, in-order response routing.
// Optional per-initiator grant counters when CXU_ARB_STATS_EN is defined.
module cxu_arbiter_n1
  import common_pkg::*;
  import cxu_pkg::*;
#(
  parameter int CXU_LI_VERSION = 'h10000,
  parameter int CXU_N_CXUS     = 4,
  parameter int CXU_N_STATES   = 0,
  parameter int CXU_CXU_ID_W   = $clog2(CXU_N_CXUS),
  parameter int CXU_STATE_ID_W = $clog2(CXU_N_STATES),
  parameter int CXU_FUNC_ID_W  = 3,
  parameter int CXU_INSN_W     = 0,
  parameter int CXU_DATA_W     = 32,
  parameter int N_INIS         = 4,
  parameter int N_REQS         = 16,
  localparam int CW    = msb(CXU_CXU_ID_W) + 1,
  localparam int SW    = msb(CXU_STATE_ID_W) + 1,
  localparam int FW    = msb(CXU_FUNC_ID_W) + 1,
  localparam int IW    = msb(CXU_INSN_W) + 1,
  localparam int DW    = msb(CXU_DATA_W) + 1,
  localparam int TAG_W = $clog2(N_INIS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic [N_INIS-1:0]            i_req_valids,
  output logic [N_INIS-1:0]            i_req_readys,
  input  logic [N_INIS*CW-1:0]         i_req_cxus,
  input  logic [N_INIS*SW-1:0]         i_req_states,
  input  logic [N_INIS*FW-1:0]         i_req_funcs,
  input  logic [N_INIS*IW-1:0]         i_req_insns,
  input  logic [N_INIS*DW-1:0]         i_req_data0s,
  input  logic [N_INIS*DW-1:0]         i_req_data1s,
  output logic [N_INIS-1:0]            i_resp_valids,
  input  logic [N_INIS-1:0]            i_resp_readys,
  output logic [N_INIS*CXU_STATUS_W-1:0] i_resp_statuss,
  output logic [N_INIS*DW-1:0]         i_resp_datas,
  output logic                         t_req_valid,
  input  logic                         t_req_ready,
  output logic [CW-1:0]                t_req_cxu,
  output logic [SW-1:0]                t_req_state,
  output logic [FW-1:0]                t_req_func,
  output logic [IW-1:0]                t_req_insn,
  output logic [DW-1:0]                t_req_data0,
  output logic [DW-1:0]                t_req_data1,
  input  logic                         t_resp_valid,
  output logic                         t_resp_ready,
  input  logic [CXU_STATUS_W-1:0]      t_resp_status,
  input  logic [DW-1:0]                t_resp_data
`ifdef CXU_ARB_STATS_EN
  ,
  output logic [32*N_INIS-1:0]         grant_cnt
`endif
);

  // Handshake rule on every channel: a transfer happens on a clock edge where
  // valid and ready are both 1 and clk_en is 1; a valid request is never
  // retracted or retargeted until it transfers (grant lock below).

  logic [TAG_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [TAG_W-1:0] r_lock_id;

  logic [TAG_W-1:0] w_srch;
  logic [TAG_W-1:0] w_idx;
  logic             w_found;
  logic [TAG_W-1:0] w_g;
  logic [TAG_W-1:0] w_g_next;
  logic [TAG_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_req_rdy;
  logic             w_req_hs;
  logic             w_resp_hs;

  always_comb begin
    w_found = 1'b0;
    w_srch  = r_rr_ptr;
    w_idx   = '0;
    for (int i = 0; i < N_INIS; i++) begin
      w_idx = TAG_W'((int'(r_rr_ptr) + i) % N_INIS);
      if (!w_found && i_req_valids[w_idx]) begin
        w_found = 1'b1;
        w_srch  = w_idx;
      end
    end
  end

  assign w_g      = r_lock ? r_lock_id : w_srch;
  assign w_g_next = (w_g == TAG_W'(N_INIS - 1)) ? '0 : w_g + 1'b1;

  // Outputs are forced low while reset is asserted, whatever the inputs do.
  assign t_req_valid  = rst_n & (|i_req_valids) & ~w_full;
  assign w_req_rdy    = rst_n & t_req_ready & ~w_full;
  assign i_req_readys = {{(N_INIS-1){1'b0}}, w_req_rdy} << w_g;
  assign w_req_hs     = t_req_valid & t_req_ready;

  assign t_req_cxu   = i_req_cxus[w_g*CW +: CW];
  assign t_req_state = i_req_states[w_g*SW +: SW];
  assign t_req_func  = i_req_funcs[w_g*FW +: FW];
  assign t_req_insn  = i_req_insns[w_g*IW +: IW];
  assign t_req_data0 = i_req_data0s[w_g*DW +: DW];
  assign t_req_data1 = i_req_data1s[w_g*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (clk_en) begin
      if (w_req_hs) begin
        r_rr_ptr <= w_g_next;
        r_lock   <= 1'b0;
      end else if (t_req_valid) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_g;
      end
    end
  end

  cxu_tag_fifo #(
    .DEPTH (N_REQS),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .i_push  (w_req_hs),
    .i_data  (w_g),
    .i_pop   (w_resp_hs),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The head tag routes the response; status and data go to everyone.
  assign i_resp_valids  = {{(N_INIS-1){1'b0}}, (t_resp_valid & ~w_empty)} << w_head;
  assign t_resp_ready   = i_resp_readys[w_head] & ~w_empty;
  assign w_resp_hs      = t_resp_valid & t_resp_ready;
  assign i_resp_statuss = {N_INIS{t_resp_status}};
  assign i_resp_datas   = {N_INIS{t_resp_data}};

`ifdef CXU_ARB_STATS_EN
  logic [31:0] r_grant_cnt [N_INIS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INIS; i++) r_grant_cnt[i] <= '0;
    end else if (clk_en && w_req_hs) begin
      r_grant_cnt[w_g] <= r_grant_cnt[w_g] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < N_INIS; gi++) begin : g_cnt
    assign grant_cnt[gi*32 +: 32] = r_grant_cnt[gi];
  end
`endif

`ifndef SYNTHESIS
  a_resp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(t_resp_valid && w_empty))
    else $error("cxu_arbiter_n1 (CXU-LI %0h): response with no outstanding request",
                CXU_LI_VERSION);
`endif

endmodule

// File: tb/tb_cxu_arbiter_n1.sv
// Directed bench for cxu_arbiter_n1: vector table for grant/lock behaviour,
// hand sequences for FIFO full, response back-pressure, clk_en and counters.
module tb_cxu_arbiter_n1;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int SW = 1;
  localparam int FW = 3;
  localparam int IW = 1;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            clk_en;
  logic [N-1:0]    i_req_valids;
  logic [N-1:0]    i_req_readys;
  logic [N*CW-1:0] i_req_cxus;
  logic [N*SW-1:0] i_req_states;
  logic [N*FW-1:0] i_req_funcs;
  logic [N*IW-1:0] i_req_insns;
  logic [N*DW-1:0] i_req_data0s;
  logic [N*DW-1:0] i_req_data1s;
  logic [N-1:0]    i_resp_valids;
  logic [N-1:0]    i_resp_readys;
  logic [N*3-1:0]  i_resp_statuss;
  logic [N*DW-1:0] i_resp_datas;
  logic            t_req_valid;
  logic            t_req_ready;
  logic [CW-1:0]   t_req_cxu;
  logic [SW-1:0]   t_req_state;
  logic [FW-1:0]   t_req_func;
  logic [IW-1:0]   t_req_insn;
  logic [DW-1:0]   t_req_data0;
  logic [DW-1:0]   t_req_data1;
  logic            t_resp_valid;
  logic            t_resp_ready;
  logic [2:0]      t_resp_status;
  logic [DW-1:0]   t_resp_data;
`ifdef CXU_ARB_STATS_EN
  logic [32*N-1:0] grant_cnt;
`endif

  cxu_arbiter_n1 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .i_req_valids   (i_req_valids),
    .i_req_readys   (i_req_readys),
    .i_req_cxus     (i_req_cxus),
    .i_req_states   (i_req_states),
    .i_req_funcs    (i_req_funcs),
    .i_req_insns    (i_req_insns),
    .i_req_data0s   (i_req_data0s),
    .i_req_data1s   (i_req_data1s),
    .i_resp_valids  (i_resp_valids),
    .i_resp_readys  (i_resp_readys),
    .i_resp_statuss (i_resp_statuss),
    .i_resp_datas   (i_resp_datas),
    .t_req_valid    (t_req_valid),
    .t_req_ready    (t_req_ready),
    .t_req_cxu      (t_req_cxu),
    .t_req_state    (t_req_state),
    .t_req_func     (t_req_func),
    .t_req_insn     (t_req_insn),
    .t_req_data0    (t_req_data0),
    .t_req_data1    (t_req_data1),
    .t_resp_valid   (t_resp_valid),
    .t_resp_ready   (t_resp_ready),
    .t_resp_status  (t_resp_status),
    .t_resp_data    (t_resp_data)
`ifdef CXU_ARB_STATS_EN
    ,
    .grant_cnt      (grant_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] valids;
    logic         ready;
    logic [N-1:0] exp_readys;
    logic         exp_valid;
    int           exp_g;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clk_en        = 1'b1;
    i_req_valids  = '0;
    t_req_ready   = 1'b0;
    i_resp_readys = '0;
    t_resp_valid  = 1'b0;
    t_resp_status = 3'd4;
    t_resp_data   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Drive one request cycle and check the granted initiator's payload.
  task automatic req_cycle(input string name, input logic [N-1:0] v, input logic rdy,
                           input logic [N-1:0] exp_rdys, input logic exp_v, input int g);
    i_req_valids = v;
    t_req_ready  = rdy;
    #1;
    chk({name, " readys"}, 64'(i_req_readys), 64'(exp_rdys));
    chk({name, " t_req_valid"}, 64'(t_req_valid), 64'(exp_v));
    if (exp_v) begin
      chk({name, " data0"}, 64'(t_req_data0), 64'(32'hA000_0000 + g));
      chk({name, " data1"}, 64'(t_req_data1), 64'(32'hB000_0000 + g));
      chk({name, " func"}, 64'(t_req_func), 64'(g + 1));
      chk({name, " cxu"}, 64'(t_req_cxu), 64'(g));
    end
    if (exp_v && rdy) exp_q.push_back(2'(g));
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < N; i++) begin
      i_req_cxus[i*CW +: CW]   = CW'(i);
      i_req_funcs[i*FW +: FW]  = FW'(i + 1);
      i_req_data0s[i*DW +: DW] = 32'hA000_0000 + i;
      i_req_data1s[i*DW +: DW] = 32'hB000_0000 + i;
    end
    i_req_states = '0;
    i_req_insns  = '0;

    // rr order from reset, skip over gaps, then grant lock under back-pressure
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    vecs[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2};
    vecs[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 0};
    vecs[7]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3};
    vecs[8]  = '{4'b0010, 1'b0, 4'b0000, 1'b1, 1};
    vecs[9]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 1};
    vecs[10] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 1};
    vecs[11] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    vecs[12] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};

    // Reset state with every initiator requesting
    idle_inputs();
    rst_n         = 1'b0;
    i_req_valids  = 4'b1111;
    t_req_ready   = 1'b1;
    i_resp_readys = 4'b1111;
    step();
    step();
    chk("rst t_req_valid", 64'(t_req_valid), 64'd0);
    chk("rst i_req_readys", 64'(i_req_readys), 64'd0);
    chk("rst i_resp_valids", 64'(i_resp_valids), 64'd0);
    chk("rst t_resp_ready", 64'(t_resp_ready), 64'd0);
    rst_n = 1'b1;
    i_resp_readys = '0;

    for (int k = 0; k < 13; k++)
      req_cycle($sformatf("vec%0d", k), vecs[k].valids, vecs[k].ready,
                vecs[k].exp_readys, vecs[k].exp_valid, vecs[k].exp_g);

    // Fill the tag FIFO, check the 17th is blocked even with a pop pending
    do_reset();
    for (int k = 0; k < 16; k++)
      req_cycle($sformatf("fill%0d", k), 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, k % 4);
    t_resp_valid  = 1'b1;
    i_resp_readys = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      int owner;
      owner        = int'(exp_q.pop_front());
      i_req_valids = (k == 0) ? 4'b1111 : 4'b0000;
      t_resp_data  = 32'(k);
      #1;
      if (k == 0) begin
        chk("full t_req_valid", 64'(t_req_valid), 64'd0);
        chk("full i_req_readys", 64'(i_req_readys), 64'd0);
      end
      chk($sformatf("drain%0d resp_valids", k), 64'(i_resp_valids), 64'(1 << owner));
      chk($sformatf("drain%0d t_resp_ready", k), 64'(t_resp_ready), 64'd1);
      chk($sformatf("drain%0d data", k), 64'(i_resp_datas[owner*DW +: DW]), 64'(k));
      chk($sformatf("drain%0d status", k), 64'(i_resp_statuss[owner*3 +: 3]), 64'd4);
      step();
    end
    t_resp_valid = 1'b0;
    #1;
    chk("drained t_resp_ready", 64'(t_resp_ready), 64'd0);

    // Response back-pressure from the head owner only
    do_reset();
    req_cycle("bp req1", 4'b0110, 1'b1, 4'b0010, 1'b1, 1);
    req_cycle("bp req2", 4'b0110, 1'b1, 4'b0100, 1'b1, 2);
    i_req_valids  = '0;
    t_resp_valid  = 1'b1;
    t_resp_data   = 32'h55;
    i_resp_readys = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("bp hold%0d t_resp_ready", k), 64'(t_resp_ready), 64'd0);
      chk($sformatf("bp hold%0d resp_valids", k), 64'(i_resp_valids), 64'b0010);
      step();
    end
    i_resp_readys = 4'b1111;
    #1;
    chk("bp pop1 resp_valids", 64'(i_resp_valids), 64'b0010);
    chk("bp pop1 t_resp_ready", 64'(t_resp_ready), 64'd1);
    step();
    chk("bp pop2 resp_valids", 64'(i_resp_valids), 64'b0100);
    chk("bp pop2 t_resp_ready", 64'(t_resp_ready), 64'd1);
    step();
    t_resp_valid = 1'b0;
    #1;
    chk("bp empty t_resp_ready", 64'(t_resp_ready), 64'd0);
    chk("bp empty resp_valids", 64'(i_resp_valids), 64'd0);

    // clk_en low: outputs follow inputs, but no push and no rr advance
    do_reset();
    clk_en = 1'b0;
    req_cycle("cken off", 4'b0100, 1'b1, 4'b0100, 1'b1, 2);
    clk_en = 1'b1;
    req_cycle("cken on", 4'b1111, 1'b1, 4'b0001, 1'b1, 0);
    i_req_valids  = '0;
    t_resp_valid  = 1'b1;
    t_resp_data   = 32'h77;
    i_resp_readys = 4'b1111;
    #1;
    chk("cken head resp_valids", 64'(i_resp_valids), 64'b0001);
    chk("cken head t_resp_ready", 64'(t_resp_ready), 64'd1);
    step();
    t_resp_valid = 1'b0;
    #1;
    chk("cken empty t_resp_ready", 64'(t_resp_ready), 64'd0);

`ifdef CXU_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++)
      req_cycle($sformatf("stat%0d", k), 4'b1000, 1'b1, 4'b1000, 1'b1, 3);
    i_req_valids = '0;
    #1;
    chk("grant_cnt[3]", 64'(grant_cnt[3*32 +: 32]), 64'd5);
    chk("grant_cnt[0]", 64'(grant_cnt[0 +: 32]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
